// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - default constants and width helper for the frequency meter
package freq_meter_pkg;

  localparam int DEF_GATE_CYCLES = 1000;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Window counter width for a gate of gate_cycles clocks (counts 0 .. gate_cycles-1).
  function automatic int win_w(input int gate_cycles);
    return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
  endfunction

  localparam int DEF_WIN_W = win_w(DEF_GATE_CYCLES);

endpackage

// File: rtl/freq_meter_if.sv
// rtl/freq_meter_if.sv - measured-signal input and result bus of the frequency meter
interface freq_meter_if
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             sig_in;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             overflow;

  // The meter drives results and samples the signal under measurement.
  modport master (
    input  sig_in,
    output count,
    output valid,
    output overflow
  );

  // The consumer (display logic) drives the signal and reads results.
  modport slave (
    output sig_in,
    input  count,
    input  valid,
    input  overflow
  );

endinterface

// File: rtl/freq_meter_sync_edge_detect.sv
// rtl/freq_meter_sync_edge_detect.sv - multi-flop synchronizer with rising-edge pulse
module sync_edge_detect
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic synced,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  // Remember the previous synced level for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= synced;
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign rise   = synced & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter measuring a slow asynchronous input
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  freq_meter_if.master bus
);

  localparam int               WIN_W    = win_w(GATE_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             unused_synced;
  logic             rise;
  logic [WIN_W-1:0] win_q;
  logic             terminal;
  logic [CNT_W-1:0] edge_q;
  logic             sat_q;
  logic             at_max;
  logic [CNT_W-1:0] close_count;
  logic             close_ovf;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             overflow_q;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(bus.sig_in),
    .synced  (unused_synced),
    .rise    (rise)
  );

  assign terminal = (win_q == WIN_LAST);

  // Free-running gate window: 0 .. GATE_CYCLES-1, then wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q <= '0;
    end else if (terminal) begin
      win_q <= '0;
    end else begin
      win_q <= win_q + WIN_W'(1);
    end
  end

  // Closing value of the window: a rise on the terminal cycle still belongs to it.
  always_comb begin
    at_max      = (edge_q == CNT_MAX);
    close_count = (at_max || !rise) ? edge_q : edge_q + CNT_W'(1);
    close_ovf   = sat_q | (at_max & rise);
  end

  // Saturating edge counter with sticky saturation flag, cleared at each window boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q <= '0;
      sat_q  <= 1'b0;
    end else if (terminal) begin
      edge_q <= '0;
      sat_q  <= 1'b0;
    end else if (rise) begin
      if (at_max) begin
        sat_q <= 1'b1;
      end else begin
        edge_q <= edge_q + CNT_W'(1);
      end
    end
  end

  // Latch the result on the terminal cycle and pulse valid for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= terminal;
      if (terminal) begin
        count_q    <= close_count;
        overflow_q <= close_ovf;
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   ph = 0;
  int   per_a = 0;
  int   per_b = 0;
  logic dc_a = 1'b0;
  logic dc_b = 1'b0;

  always #5 clk = ~clk;

  freq_meter_if #(.CNT_W(8)) if_a ();
  freq_meter_if #(.CNT_W(4)) if_b ();

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(if_a.master)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(if_b.master)
  );

  task automatic drive_sig();
    if (per_a == 0) if_a.sig_in = dc_a;
    else            if_a.sig_in = ((ph % per_a) < (per_a / 2));
    if (per_b == 0) if_b.sig_in = dc_b;
    else            if_b.sig_in = ((ph % per_b) < (per_b / 2));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
    drive_sig();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ph = 0;
    drive_sig();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    per_a = 0; per_b = 0; dc_a = 1'b0; dc_b = 1'b0;
    rst = 1'b0;
    drive_sig();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if_a.sig_in = ~if_a.sig_in;
      if_b.sig_in = ~if_b.sig_in;
      tests++;
      if ({if_a.count, if_a.valid, if_a.overflow} !== 10'd0 ||
          {if_b.count, if_b.valid, if_b.overflow} !== 6'd0) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: a cnt=%0d v=%b o=%b b cnt=%0d v=%b o=%b (want all 0)",
                 i, if_a.count, if_a.valid, if_a.overflow, if_b.count, if_b.valid, if_b.overflow);
      end
    end
    ph = 0;
    drive_sig();
    rst = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      tests++;
      if (if_a.valid !== (i == 100) || if_b.valid !== (i == 100)) begin
        fails++;
        $display("FAIL first_valid cyc %0d: a=%b b=%b want %b", i, if_a.valid, if_b.valid, (i == 100));
      end
    end
    tests++;
    if (if_a.count !== 8'd0 || if_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_first_count: cnt=%0d o=%b want 0/0", if_a.count, if_a.overflow);
    end
  endtask

  task automatic test_steady();
    per_a = 10;
    do_reset();
    for (int i = 1; i <= 400; i++) begin
      tick();
      tests++;
      if (if_a.valid !== (ph % 100 == 0)) begin
        fails++;
        $display("FAIL steady_valid ph %0d: got %b want %b", ph, if_a.valid, (ph % 100 == 0));
      end
      if (ph % 100 == 0 && ph > 100) begin
        tests++;
        if (if_a.count !== 8'd10 || if_a.overflow !== 1'b0) begin
          fails++;
          $display("FAIL steady_count ph %0d: cnt=%0d o=%b want 10/0", ph, if_a.count, if_a.overflow);
        end
      end
    end
  endtask

  task automatic test_dc();
    per_a = 0; dc_a = 1'b0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (ph % 100 == 0) begin
        tests++;
        if (if_a.count !== 8'd0) begin
          fails++;
          $display("FAIL dc_low ph %0d: cnt=%0d want 0", ph, if_a.count);
        end
      end
    end
    dc_a = 1'b1;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (ph == 100) begin
        tests++;
        if (if_a.count !== 8'd1) begin
          fails++;
          $display("FAIL dc_high_first: cnt=%0d want 1", if_a.count);
        end
      end
      if (ph == 200) begin
        tests++;
        if (if_a.count !== 8'd0) begin
          fails++;
          $display("FAIL dc_high_second: cnt=%0d want 0", if_a.count);
        end
      end
    end
  endtask

  task automatic test_saturation();
    per_b = 4;
    do_reset();
    for (int i = 1; i <= 600; i++) begin
      tick();
      if (ph == 200 || ph == 300) begin
        tests++;
        if (if_b.count !== 4'd15 || if_b.overflow !== 1'b1 || if_b.valid !== 1'b1) begin
          fails++;
          $display("FAIL sat ph %0d: cnt=%0d o=%b v=%b want 15/1/1", ph, if_b.count, if_b.overflow, if_b.valid);
        end
      end
      if (ph == 300) begin
        per_b = 20;
        drive_sig();
      end
      if (ph == 500 || ph == 600) begin
        tests++;
        if (if_b.count !== 4'd5 || if_b.overflow !== 1'b0 || if_b.valid !== 1'b1) begin
          fails++;
          $display("FAIL unsat ph %0d: cnt=%0d o=%b v=%b want 5/0/1", ph, if_b.count, if_b.overflow, if_b.valid);
        end
      end
    end
  endtask

  task automatic test_terminal_edge();
    per_a = 0; dc_a = 1'b0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (ph == 100) begin
        tests++;
        if (if_a.count !== 8'd2) begin
          fails++;
          $display("FAIL term_edge_close: cnt=%0d want 2", if_a.count);
        end
      end
      if (ph == 200) begin
        tests++;
        if (if_a.count !== 8'd0) begin
          fails++;
          $display("FAIL term_edge_next: cnt=%0d want 0", if_a.count);
        end
      end
      if (ph == 10) dc_a = 1'b1;
      if (ph == 20) dc_a = 1'b0;
      if (ph == 97) dc_a = 1'b1;
      drive_sig();
    end
    dc_a = 1'b0;
    do_reset();
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (ph == 100) begin
        tests++;
        if (if_a.count !== 8'd0) begin
          fails++;
          $display("FAIL after_term_close: cnt=%0d want 0", if_a.count);
        end
      end
      if (ph == 200) begin
        tests++;
        if (if_a.count !== 8'd1) begin
          fails++;
          $display("FAIL after_term_next: cnt=%0d want 1", if_a.count);
        end
      end
      if (ph == 98) dc_a = 1'b1;
      drive_sig();
    end
  endtask

  task automatic test_reset_mid();
    per_a = 10;
    do_reset();
    for (int i = 1; i <= 150; i++) tick();
    tests++;
    if (if_a.count !== 8'd10) begin
      fails++;
      $display("FAIL mid_pre_count: cnt=%0d want 10", if_a.count);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (if_a.count !== 8'd0 || if_a.valid !== 1'b0 || if_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL mid_async_clear: cnt=%0d v=%b o=%b want 0/0/0", if_a.count, if_a.valid, if_a.overflow);
    end
    repeat (2) @(posedge clk);
    #1;
    ph = 0;
    drive_sig();
    rst = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      tests++;
      if (if_a.valid !== (ph == 100)) begin
        fails++;
        $display("FAIL mid_valid ph %0d: got %b want %b", ph, if_a.valid, (ph == 100));
      end
    end
    tests++;
    if (if_a.count !== 8'd10 || if_a.overflow !== 1'b0) begin
      fails++;
      $display("FAIL mid_count: cnt=%0d o=%b want 10/0", if_a.count, if_a.overflow);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.sig_in = 1'b0;
    if_b.sig_in = 1'b0;
    test_reset();
    test_steady();
    test_dc();
    test_saturation();
    test_terminal_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures the frequency of a slow, asynchronous square-wave input, such as a divided display clock.
- Counts rising edges of `sig_in` over a fixed gate window of `GATE_CYCLES` system clocks.
- At the end of each window it latches the edge count and pulses `valid`; windows repeat back-to-back.
- Sits beside the seven-segment path: `count` feeds the display digit logic, and the block self-checks the divided clocks.

Parameters:
- `GATE_CYCLES`, default 1000: gate window length in `clk` cycles; must be ≥ 2.
- `CNT_W`, default 16: width of the edge counter and of `count`.
- `SYNC_STAGES`, default 2: flip-flop stages in the `sig_in` synchronizer; must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `sig_in`  in  1  signal under measurement; asynchronous to `clk`.
- `count`  out  `CNT_W`  rising-edge count of the last completed window.
- `valid`  out  1  one-cycle pulse when `count` updates.
- `overflow`  out  1  set if the last completed window saturated.

Behaviour:
- **Reset.** `rst`=0 immediately clears the synchronizer, edge-detect register, window counter, edge counter, `count`, `valid` and `overflow`, all to 0. After `rst` deasserts, the first window starts on the next `clk` edge.
- **Synchronizer.** `sig_in` passes through `SYNC_STAGES` flops, then one extra register for edge detection. `rise` = synced & ~prev.
- **Latency.** A `sig_in` rise is counted `SYNC_STAGES`+1 cycles later (3 at default).
- **Startup.** The synced value is 0 after reset, so a `sig_in` held high through reset produces exactly one counted rise after release.
- **Window counter.** Runs 0 … `GATE_CYCLES`-1, then wraps to 0. Terminal cycle = window counter at `GATE_CYCLES`-1.
- **Edge counter.** Increments on `rise`. Saturates at 2^`CNT_W`-1; a sticky `sat` flag is set when a rise arrives while the counter is already at maximum.
- **On the terminal cycle:**
  - `count` ← edge counter + `rise`, saturated.
  - `overflow` ← `sat` OR (counter at max AND `rise`).
  - `valid` = 1 for exactly that next cycle.
  - Edge counter and `sat` clear to 0 for the new window.
  - A rise on the terminal cycle belongs to the closing window, never to the new one.
- **Holding outputs.** `count` and `overflow` hold between `valid` pulses. `valid` is 0 at all other times.
- **Measured frequency.** f_sig = `count` × f_clk / `GATE_CYCLES`.
- **Reset mid-window.** The partial window is discarded; no `valid` is produced. After release, the first `valid` arrives `GATE_CYCLES` cycles after the first post-reset clock edge.
- **Faster than clk/2.** Edges may be missed. No error is flagged; this is outside the spec.

Decomposition:
- Package `freq_meter_pkg` holds the default constants: `DEF_GATE_CYCLES`, `DEF_CNT_W`, `DEF_SYNC_STAGES`. It also holds the window-counter width, computed as clog2(`GATE_CYCLES`).
- Sub-module `sync_edge_detect`, parameterised by `SYNC_STAGES`:
  - inputs `clk`, `rst`, async input;
  - outputs the synced level and a one-cycle `rise` pulse.
- Top level = window counter + saturating edge counter + output latch.

Test Plan:
- **Reset values.** Hold `rst`=0 for 5 cycles while toggling `sig_in` → `count`=0, `valid`=0, `overflow`=0 throughout. Deassert → first `valid` exactly `GATE_CYCLES` cycles later.
- **Steady frequency.** `GATE_CYCLES`=100, `CNT_W`=8, `sig_in` period 10 `clk` (5 high / 5 low) → every window after the first: `count`=10, `overflow`=0. `valid` pulses every 100 cycles, exactly 1 cycle wide.
- **DC input.** `sig_in` held 0 → `count`=0 every window. `sig_in` held 1 from reset → first window `count`=1, later windows `count`=0.
- **Saturation.** `GATE_CYCLES`=100, `CNT_W`=4, `sig_in` period 4 (25 edges per window) → `count`=15, `overflow`=1. Then switch to period 20 → next full window `count`=5, `overflow`=0.
- **Terminal-cycle edge.** Align a synced rise to the terminal cycle → it is counted in the closing `count`, and the next window's count excludes it.
- **Reset mid-window.** Pulse `rst` low at window cycle 50 → outputs zero immediately, no `valid` for the aborted window. The next `valid` arrives 100 cycles after release with the correct count.
